// File: rtl/input_router_ctrl_pkg.sv
// Shared types and default sizing for the input-router row-group sequencer.
// Imported by the interface and the controller.
package input_router_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        AGEN  = 3'd2,
        FETCH = 3'd3,
        FWAIT = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } irc_state_e;

    typedef logic [1:0] p_mode_t;

    localparam int unsigned IRC_ROUTER_COUNT = 4;
    localparam int unsigned IRC_ADDR_WIDTH   = 8;
    localparam int unsigned IRC_SPAD_LAT     = 1;
    localparam int unsigned IRC_CNT_WIDTH    = 9;
    // Row id is carried zero-extended to one bit per router.
    localparam int unsigned IRC_ROW_ID_W     = IRC_ROUTER_COUNT;

endpackage

// File: rtl/input_router_ctrl_if.sv
// Control bundle between the layer scheduler / row group and the sequencer.
// i_start is valid and ~o_busy is ready: a tile is accepted on a cycle where both are high.
interface input_router_ctrl_if
    import input_router_pkg::*;
#(
    parameter int unsigned ROUTER_COUNT = IRC_ROUTER_COUNT,
    parameter int unsigned ADDR_WIDTH   = IRC_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH    = IRC_CNT_WIDTH
) ();
    logic                    i_start;
    logic                    i_abort;
    p_mode_t                 i_p_mode;
    logic [ADDR_WIDTH-1:0]   i_spad_base;
    logic [CNT_WIDTH-1:0]    i_spad_words;
    logic                    i_rg_addr_empty;
    logic                    i_rg_data_empty;
    logic                    o_reg_clear;
    logic                    o_ag_en;
    logic                    o_ag_valid;
    logic [ROUTER_COUNT-1:0] o_row_id;
    logic                    o_ac_en;
    logic                    o_spad_rd_en;
    logic [ADDR_WIDTH-1:0]   o_spad_rd_addr;
    logic                    o_miso_pop_en;
    p_mode_t                 o_p_mode;
    logic                    o_busy;
    logic                    o_done;
    irc_state_e              o_state;

    modport slave (
        input  i_start, i_abort, i_p_mode, i_spad_base, i_spad_words,
               i_rg_addr_empty, i_rg_data_empty,
        output o_reg_clear, o_ag_en, o_ag_valid, o_row_id, o_ac_en, o_spad_rd_en,
               o_spad_rd_addr, o_miso_pop_en, o_p_mode, o_busy, o_done, o_state
    );

    modport master (
        output i_start, i_abort, i_p_mode, i_spad_base, i_spad_words,
               i_rg_addr_empty, i_rg_data_empty,
        input  o_reg_clear, o_ag_en, o_ag_valid, o_row_id, o_ac_en, o_spad_rd_en,
               o_spad_rd_addr, o_miso_pop_en, o_p_mode, o_busy, o_done, o_state
    );

endinterface

// File: rtl/input_router_ctrl.sv
// Tile sequencer for one input-router row group: clear, address-gen load,
// scratchpad fetch, MISO drain. All outputs are registered decodes of the next state.
module input_router_ctrl
    import input_router_pkg::*;
#(
    parameter int unsigned ROUTER_COUNT = IRC_ROUTER_COUNT,
    parameter int unsigned ADDR_WIDTH   = IRC_ADDR_WIDTH,
    parameter int unsigned SPAD_LAT     = IRC_SPAD_LAT,
    parameter int unsigned CNT_WIDTH    = IRC_CNT_WIDTH
) (
    input logic                i_clk,
    input logic                i_nrst,
    input_router_ctrl_if.slave bus
);
    localparam logic [CNT_WIDTH:0] RC_CYC  = (CNT_WIDTH+1)'(ROUTER_COUNT);
    localparam logic [CNT_WIDTH:0] LAT_CYC = (CNT_WIDTH+1)'(SPAD_LAT);
    localparam logic [CNT_WIDTH:0] ONE_X   = (CNT_WIDTH+1)'(1);

    irc_state_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CNT_WIDTH:0]      cnt_ext;
    logic                    abort_clr_q, abort_clr_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0]    words_q;
    p_mode_t                 p_mode_q;
    logic [ROUTER_COUNT-1:0] row_id_q, row_id_d;
    logic                    reg_clear_q, ag_en_q, ac_en_q, rd_en_q;
    logic                    pop_en_q, busy_q, done_q;
    logic                    start_acc;

    assign start_acc = (state_q == IDLE) && bus.i_start;
    // Cycles spent in the current state including this one; one bit wider so it never wraps.
    assign cnt_ext   = {1'b0, cnt_q} + ONE_X;

    always_comb begin
        state_d     = state_q;
        abort_clr_d = abort_clr_q;
        if ((state_q != IDLE) && bus.i_abort) begin
            state_d     = CLEAR;
            abort_clr_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        state_d     = CLEAR;
                        abort_clr_d = 1'b0;
                    end
                end
                CLEAR: state_d = abort_clr_q ? IDLE : AGEN;
                AGEN: begin
                    if (cnt_ext == RC_CYC) state_d = (words_q == '0) ? FWAIT : FETCH;
                end
                FETCH: begin
                    if (cnt_ext == {1'b0, words_q}) state_d = FWAIT;
                end
                FWAIT: begin
                    if ((cnt_ext >= LAT_CYC) && bus.i_rg_addr_empty) state_d = DRAIN;
                end
                DRAIN: begin
                    if ((cnt_ext >= RC_CYC) && bus.i_rg_data_empty) state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = (state_d != state_q) ? '0 :
                   ((&cnt_q) ? cnt_q : cnt_ext[CNT_WIDTH-1:0]);
        row_id_d = (state_d == AGEN) ? ROUTER_COUNT'(cnt_d) : '0;
        addr_d   = addr_q;
        if (state_d == FETCH) begin
            addr_d = (state_q == FETCH) ? (addr_q + ADDR_WIDTH'(1)) : base_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            abort_clr_q <= 1'b0;
            base_q      <= '0;
            words_q     <= '0;
            p_mode_q    <= '0;
            addr_q      <= '0;
            row_id_q    <= '0;
            reg_clear_q <= 1'b0;
            ag_en_q     <= 1'b0;
            ac_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            pop_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abort_clr_q <= abort_clr_d;
            addr_q      <= addr_d;
            row_id_q    <= row_id_d;
            if (start_acc) begin
                base_q   <= bus.i_spad_base;
                words_q  <= bus.i_spad_words;
                p_mode_q <= bus.i_p_mode;
            end
            reg_clear_q <= (state_d == CLEAR);
            ag_en_q     <= (state_d == AGEN);
            ac_en_q     <= (state_d == FETCH) || (state_d == FWAIT);
            rd_en_q     <= (state_d == FETCH);
            pop_en_q    <= (state_d == DRAIN);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign bus.o_reg_clear    = reg_clear_q;
    assign bus.o_ag_en        = ag_en_q;
    assign bus.o_ag_valid     = ag_en_q;
    assign bus.o_row_id       = row_id_q;
    assign bus.o_ac_en        = ac_en_q;
    assign bus.o_spad_rd_en   = rd_en_q;
    assign bus.o_spad_rd_addr = addr_q;
    assign bus.o_miso_pop_en  = pop_en_q;
    assign bus.o_p_mode       = p_mode_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;
    assign bus.o_state        = state_q;

endmodule

// File: tb/tb_input_router_ctrl.sv
// Randomised bench for input_router_ctrl: a phase-arithmetic tile model drives a per-cycle
// timeline check, and a negedge monitor scores beats, reads, clears and done against queues.
module tb_input_router_ctrl;
    import input_router_pkg::*;

    localparam int RC  = 4;
    localparam int AW  = 8;
    localparam int CW  = 9;
    localparam int LAT = 1;

    logic i_clk  = 1'b0;
    logic i_nrst = 1'b1;

    always #5 i_clk = ~i_clk;

    input_router_ctrl_if #(.ROUTER_COUNT(RC), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    input_router_ctrl #(
        .ROUTER_COUNT(RC), .ADDR_WIDTH(AW), .SPAD_LAT(LAT), .CNT_WIDTH(CW)
    ) dut (
        .i_clk (i_clk),
        .i_nrst(i_nrst),
        .bus   (bus)
    );

    logic [RC-1:0] exp_row_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [1:0]    exp_pm_q[$];
    logic [0:0]    exp_clr_q[$];
    logic [AW-1:0] last_addr;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Tile phases with empties held low for ha/hd cycles after FWAIT/DRAIN entry.
    function automatic int done_cycle(input int words, input int ha, input int hd);
        int f, p;
        f = 2 + RC + words;
        p = imax(f + LAT - 1, f + ha) + 1;
        return imax(p + RC - 1, p + hd) + 1;
    endfunction

    function automatic logic [7:0] exp_vec(input int c, input int words, input int ha,
                                           input int hd, input int a);
        int   f, p, d;
        logic clr, ag, rd, fw, pop, dn, bz;
        if (a != 0 && c == a + 1) return 8'b1000_0001;
        if (a != 0 && c > a + 1) return 8'h00;
        f   = 2 + RC + words;
        p   = imax(f + LAT - 1, f + ha) + 1;
        d   = done_cycle(words, ha, hd);
        clr = (c == 1);
        ag  = (c >= 2) && (c <= 1 + RC);
        rd  = (c >= 2 + RC) && (c <= 1 + RC + words);
        fw  = (c >= f) && (c < p);
        pop = (c >= p) && (c < d);
        dn  = (c == d);
        bz  = (c >= 1) && (c <= d);
        return {clr, ag, ag, rd, rd | fw, pop, dn, bz};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {bus.o_reg_clear, bus.o_ag_en, bus.o_ag_valid, bus.o_spad_rd_en,
                bus.o_ac_en, bus.o_miso_pop_en, bus.o_done, bus.o_busy};
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({bus.o_reg_clear, bus.o_ag_en, bus.o_ag_valid, bus.o_row_id, bus.o_ac_en,
                    bus.o_spad_rd_en, bus.o_spad_rd_addr, bus.o_miso_pop_en, bus.o_p_mode,
                    bus.o_busy, bus.o_done});
    endfunction

    task automatic rand_junk();
        bus.i_spad_base  = AW'($urandom);
        bus.i_spad_words = CW'($urandom);
        bus.i_p_mode     = 2'($urandom);
    endtask

    always @(negedge i_clk) begin
        if (!i_nrst) begin
            last_addr = '0;
        end else begin
            if (bus.o_reg_clear) begin
                if (exp_clr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL reg_clear: got pulse, expected none");
                end else check("reg_clear", 64'(bus.o_reg_clear), 64'(exp_clr_q.pop_front()));
            end
            if (bus.o_ag_valid) begin
                if (exp_row_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL ag_beat: got row_id %0d, expected no beat", bus.o_row_id);
                end else check("ag_row_id", 64'(bus.o_row_id), 64'(exp_row_q.pop_front()));
            end
            if (bus.o_spad_rd_en) begin
                if (exp_addr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL spad_read: got addr 0x%0h, expected no read", bus.o_spad_rd_addr);
                end else begin
                    last_addr = exp_addr_q.pop_front();
                    check("spad_rd_addr", 64'(bus.o_spad_rd_addr), 64'(last_addr));
                end
            end else begin
                check("rd_addr_hold", 64'(bus.o_spad_rd_addr), 64'(last_addr));
            end
            if (bus.o_done) begin
                if (exp_pm_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done: got pulse, expected none");
                end else check("done_p_mode", 64'(bus.o_p_mode), 64'(exp_pm_q.pop_front()));
            end
        end
    end

    task automatic run_tile(input logic [AW-1:0] base, input int words, input logic [1:0] pm,
                            input int abort_at, input int ha, input int hd, input bit busy_start);
        int            f, p, last_c;
        logic [AW-1:0] a8;
        f      = 2 + RC + words;
        p      = imax(f + LAT - 1, f + ha) + 1;
        last_c = (abort_at != 0) ? abort_at + 2 : done_cycle(words, ha, hd) + 1;
        exp_clr_q.push_back(1'b1);
        if (abort_at != 0) exp_clr_q.push_back(1'b1);
        for (int i = 0; i < RC; i++)
            if (abort_at == 0 || 2 + i <= abort_at) exp_row_q.push_back(RC'(i));
        for (int k = 0; k < words; k++) begin
            if (abort_at == 0 || 2 + RC + k <= abort_at) begin
                a8 = base + AW'(k);
                exp_addr_q.push_back(a8);
            end
        end
        if (abort_at == 0) exp_pm_q.push_back(pm);

        bus.i_start      = 1'b1;
        bus.i_abort      = 1'b0;
        bus.i_spad_base  = base;
        bus.i_spad_words = CW'(words);
        bus.i_p_mode     = pm;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            check($sformatf("timeline c=%0d", c), 64'(dut_vec()),
                  64'(exp_vec(c, words, ha, hd, abort_at)));
            if (c == 1) check("p_mode_latched", 64'(bus.o_p_mode), 64'(pm));
            rand_junk();
            bus.i_abort = (c == abort_at);
            bus.i_start = busy_start && (c == 3) && (abort_at == 0 || abort_at >= 2);
            bus.i_rg_addr_empty = (c < f) ? 1'($urandom_range(0, 1)) : (c >= f + ha);
            bus.i_rg_data_empty = (c < p) ? 1'($urandom_range(0, 1)) : (c >= p + hd);
            @(posedge i_clk); #1;
        end
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        check("queues_drained",
              64'(exp_row_q.size() + exp_addr_q.size() + exp_pm_q.size() + exp_clr_q.size()),
              64'(0));
    endtask

    initial begin
        int words, ha, hd, ab;
        bit bs;
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_p_mode = '0;
        bus.i_spad_base = '0; bus.i_spad_words = '0;
        bus.i_rg_addr_empty = 1'b1; bus.i_rg_data_empty = 1'b1;
        #1 i_nrst = 1'b0;

        // Reset held while every input toggles.
        repeat (6) begin
            @(posedge i_clk); #1;
            rand_junk();
            bus.i_start = 1'($urandom_range(0, 1));
            bus.i_abort = 1'($urandom_range(0, 1));
            bus.i_rg_addr_empty = 1'($urandom_range(0, 1));
            bus.i_rg_data_empty = 1'($urandom_range(0, 1));
            check("reset_outputs", all_outs(), 64'(0));
        end
        bus.i_start = 1'b0; bus.i_abort = 1'b0;
        @(negedge i_clk); #2 i_nrst = 1'b1;
        @(posedge i_clk); #1;
        check("idle_after_reset", all_outs(), 64'(0));

        run_tile(8'h10, 3, 2'd1, 0, 0, 0, 1'b0);
        run_tile(8'hFE, 3, 2'd2, 0, 0, 0, 1'b0);
        run_tile(8'h33, 0, 2'd3, 0, 0, 0, 1'b0);
        run_tile(8'h20, 8, 2'd1, 2 + RC + 2, 0, 0, 1'b0);
        run_tile(8'h50, 2, 2'd0, 1, 0, 0, 1'b0);
        run_tile(8'h60, 5, 2'd2, 0, 0, 0, 1'b1);
        run_tile(8'h70, 2, 2'd1, 0, 3, 10, 1'b0);

        bus.i_abort = 1'b1;
        @(posedge i_clk); #1;
        bus.i_abort = 1'b0;
        check("abort_in_idle", 64'(dut_vec()), 64'(0));

        // Asynchronous reset in the middle of FETCH.
        exp_clr_q.push_back(1'b1);
        for (int i = 0; i < RC; i++) exp_row_q.push_back(RC'(i));
        exp_addr_q.push_back(8'h40);
        bus.i_start = 1'b1; bus.i_spad_base = 8'h40; bus.i_spad_words = 9'd6; bus.i_p_mode = 2'd3;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        repeat (6) begin
            @(posedge i_clk); #1;
        end
        #2 i_nrst = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 64'(0));
        @(negedge i_clk); #2 i_nrst = 1'b1;
        @(posedge i_clk); #1;
        check("idle_after_mid_reset", all_outs(), 64'(0));
        check("mid_reset_queues",
              64'(exp_row_q.size() + exp_addr_q.size() + exp_pm_q.size() + exp_clr_q.size()),
              64'(0));

        for (int t = 0; t < 40; t++) begin
            words = $urandom_range(0, 12);
            ha    = $urandom_range(0, 4);
            hd    = $urandom_range(0, 8);
            ab    = ($urandom_range(0, 3) == 0) ?
                    $urandom_range(1, done_cycle(words, ha, hd) - 1) : 0;
            bs    = ($urandom_range(0, 3) == 0);
            run_tile(AW'($urandom), words, 2'($urandom), ab, ha, hd, bs);
            repeat ($urandom_range(0, 2)) begin
                rand_junk();
                @(posedge i_clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
